// File: rtl/threshold_reset_monitor_pkg.sv
// threshold_reset_monitor_pkg: shared enums for the threshold reset monitor
package threshold_reset_monitor_pkg;
  typedef enum logic {WINDOW = 1'b0, EXACT = 1'b1} mode_e;
  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} ch_state_e;
endpackage

// File: rtl/threshold_reset_monitor_if.sv
// threshold_reset_monitor_if: control inputs and result outputs of the monitor
interface threshold_reset_monitor_if
  import threshold_reset_monitor_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
);
  logic enable;
  mode_e mode;
  logic [WIDTH-1:0] threshold;
  logic [NUM_CH*WIDTH-1:0] value;
  logic clear;
  logic [NUM_CH-1:0] pass_pulse;
  logic [NUM_CH-1:0] fail_pulse;
  logic [NUM_CH-1:0] fail_sticky;
  logic [CNT_W-1:0] fail_count;
  logic first_fail_valid;
  logic [CH_W-1:0] first_fail_ch;
  modport master(output enable, mode, threshold, value, clear,
                 input pass_pulse, fail_pulse, fail_sticky, fail_count, first_fail_valid, first_fail_ch);
  modport slave(input enable, mode, threshold, value, clear,
                output pass_pulse, fail_pulse, fail_sticky, fail_count, first_fail_valid, first_fail_ch);
endinterface

// File: rtl/threshold_reset_monitor_ch.sv
// threshold_reset_monitor_ch: one channel's trigger/response check FSM
module threshold_reset_monitor_ch
  import threshold_reset_monitor_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEADLINE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  mode_e mode,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] value,
  output logic pass_pulse,
  output logic fail_pulse,
  output logic fail_now
);
  localparam int K_W = $clog2(DEADLINE + 1);
  ch_state_e state, state_n;
  mode_e mode_q, mode_n;
  logic [K_W-1:0] k, k_n, k_inc;
  logic pass_now, trig, due;
  assign trig = enable && value > threshold;
  assign k_inc = k + 1'b1;
  assign due = k_inc == K_W'(DEADLINE);
  // Decide the running check; a fail with value still above threshold re-arms at once
  always_comb begin
    state_n = state;
    k_n = k;
    mode_n = mode_q;
    pass_now = 1'b0;
    fail_now = 1'b0;
    if (state == ARMED) begin
      k_n = k_inc;
      pass_now = value == '0 && (mode_q == WINDOW || due);
      fail_now = due && value != '0;
      if (pass_now || fail_now) state_n = IDLE;
    end
    if (trig && (state == IDLE || fail_now)) begin
      state_n = ARMED;
      k_n = '0;
      mode_n = mode;
    end
    if (!enable) begin
      state_n = IDLE;
      pass_now = 1'b0;
      fail_now = 1'b0;
    end
  end
  // State register and registered result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      mode_q <= WINDOW;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      mode_q <= mode_n;
      pass_pulse <= pass_now;
      fail_pulse <= fail_now;
    end
  end
endmodule

// File: rtl/threshold_reset_monitor.sv
// threshold_reset_monitor: per-channel response checks with fail aggregation
module threshold_reset_monitor
  import threshold_reset_monitor_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH = 4,
  parameter int DEADLINE = 2,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  threshold_reset_monitor_if.slave bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SW = CNT_W + 6;
  logic [NUM_CH-1:0] pass_q, fail_q, fail_now, sticky;
  logic [CNT_W-1:0] count, cnt_base, cnt_n;
  logic [SW-1:0] sum;
  logic [4:0] n_fail;
  logic [CH_W-1:0] low, ff_ch;
  logic ff_valid, valid_base;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    threshold_reset_monitor_ch #(.WIDTH(WIDTH), .DEADLINE(DEADLINE)) u_ch (
      .clk(clk),
      .rst(rst),
      .enable(bus.enable),
      .mode(bus.mode),
      .threshold(bus.threshold),
      .value(bus.value[i*WIDTH +: WIDTH]),
      .pass_pulse(pass_q[i]),
      .fail_pulse(fail_q[i]),
      .fail_now(fail_now[i])
    );
  end
  // Count this edge's fails, find the lowest failing channel, saturate the total
  always_comb begin
    n_fail = '0;
    low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      n_fail = n_fail + 5'(fail_now[i]);
      if (fail_now[i]) low = CH_W'(i);
    end
    cnt_base = bus.clear ? '0 : count;
    valid_base = !bus.clear && ff_valid;
    sum = SW'(cnt_base) + SW'(n_fail);
    cnt_n = sum > SW'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0];
  end
  // Sticky flags, fail total and first-fail capture; new fails win over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '0;
      count <= '0;
      ff_valid <= 1'b0;
      ff_ch <= '0;
    end else begin
      sticky <= (bus.clear ? '0 : sticky) | fail_now;
      count <= cnt_n;
      if (!valid_base && |fail_now) begin
        ff_valid <= 1'b1;
        ff_ch <= low;
      end else if (bus.clear) begin
        ff_valid <= 1'b0;
        ff_ch <= '0;
      end
    end
  end
  assign bus.pass_pulse = pass_q;
  assign bus.fail_pulse = fail_q;
  assign bus.fail_sticky = sticky;
  assign bus.fail_count = count;
  assign bus.first_fail_valid = ff_valid;
  assign bus.first_fail_ch = ff_ch;
endmodule

// File: tb/tb_threshold_reset_monitor.sv
// tb_threshold_reset_monitor: directed and random stimulus against a behavioural model
module tb_threshold_reset_monitor;
  import threshold_reset_monitor_pkg::*;
  localparam int DL = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  threshold_reset_monitor_if #(.NUM_CH(2), .WIDTH(4), .CNT_W(8)) if8();
  threshold_reset_monitor_if #(.NUM_CH(2), .WIDTH(4), .CNT_W(2)) if2();
  threshold_reset_monitor #(.NUM_CH(2), .WIDTH(4), .DEADLINE(DL), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  threshold_reset_monitor #(.NUM_CH(2), .WIDTH(4), .DEADLINE(DL), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  always #5 clk = ~clk;
  bit m_armed[2];
  int m_start[2];
  bit m_mode[2];
  bit e_pass[2], e_fail[2], e_sticky[2];
  int e_cnt8, e_cnt2, e_ch, edge_no;
  bit e_valid;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, edge_no);
    end
  endtask
  task automatic step(bit r, bit en, bit md, int thr, int v0, int v1, bit clr);
    int v[2];
    int nf, low, age;
    @(negedge clk);
    rst = r;
    if8.enable = en; if2.enable = en;
    if8.mode = mode_e'(md); if2.mode = mode_e'(md);
    if8.threshold = 4'(thr); if2.threshold = 4'(thr);
    if8.value = {4'(v1), 4'(v0)}; if2.value = {4'(v1), 4'(v0)};
    if8.clear = clr; if2.clear = clr;
    edge_no++;
    v[0] = v0; v[1] = v1;
    nf = 0; low = -1;
    for (int c = 0; c < 2; c++) begin
      e_pass[c] = 0; e_fail[c] = 0;
      if (r || !en) m_armed[c] = 0;
      else begin
        if (m_armed[c]) begin
          age = edge_no - m_start[c];
          if (v[c] == 0 && (m_mode[c] == 0 || age == DL)) begin e_pass[c] = 1; m_armed[c] = 0; end
          else if (age == DL) begin e_fail[c] = 1; m_armed[c] = 0; end
        end
        if (!m_armed[c] && v[c] > thr) begin
          m_armed[c] = 1; m_start[c] = edge_no; m_mode[c] = md;
        end
      end
      if (e_fail[c]) begin nf++; if (low < 0) low = c; end
    end
    if (r) begin
      e_sticky = '{0, 0}; e_cnt8 = 0; e_cnt2 = 0; e_valid = 0; e_ch = 0;
    end else begin
      if (clr) begin e_sticky = '{0, 0}; e_cnt8 = 0; e_cnt2 = 0; e_valid = 0; e_ch = 0; end
      for (int c = 0; c < 2; c++) e_sticky[c] |= e_fail[c];
      e_cnt8 = (e_cnt8 + nf > 255) ? 255 : e_cnt8 + nf;
      e_cnt2 = (e_cnt2 + nf > 3) ? 3 : e_cnt2 + nf;
      if (!e_valid && nf > 0) begin e_valid = 1; e_ch = low; end
    end
    @(posedge clk);
    #1;
    chk("pass_pulse", 32'(if8.pass_pulse), {30'd0, e_pass[1], e_pass[0]});
    chk("fail_pulse", 32'(if8.fail_pulse), {30'd0, e_fail[1], e_fail[0]});
    chk("fail_sticky", 32'(if8.fail_sticky), {30'd0, e_sticky[1], e_sticky[0]});
    chk("fail_count", 32'(if8.fail_count), 32'(e_cnt8));
    chk("ff_valid", 32'(if8.first_fail_valid), 32'(e_valid));
    chk("ff_ch", 32'(if8.first_fail_ch), 32'(e_ch));
    chk("fail_count_sat", 32'(if2.fail_count), 32'(e_cnt2));
    chk("fail_pulse_sat", 32'(if2.fail_pulse), {30'd0, e_fail[1], e_fail[0]});
  endtask
  initial begin
    int thr, md;
    edge_no = 0;
    step(1, 0, 0, 8, 0, 0, 0);
    step(1, 1, 0, 8, 12, 12, 1);
    chk("reset_count", 32'(if8.fail_count), 32'd0);
    chk("reset_valid", 32'(if8.first_fail_valid), 32'd0);
    step(0, 1, 0, 8, 9, 0, 0);
    step(0, 1, 0, 8, 0, 0, 0);
    chk("window_pass", 32'(if8.pass_pulse), 32'd1);
    step(0, 1, 0, 8, 0, 0, 0);
    step(0, 1, 1, 8, 9, 0, 0);
    step(0, 1, 0, 8, 0, 0, 0);
    step(0, 1, 0, 8, 3, 0, 0);
    chk("exact_fail", 32'(if8.fail_pulse), 32'd1);
    step(0, 1, 0, 8, 0, 0, 0);
    step(0, 1, 0, 8, 12, 12, 0);
    step(0, 1, 0, 8, 12, 12, 0);
    step(0, 1, 0, 8, 12, 12, 0);
    chk("both_fail", 32'(if8.fail_pulse), 32'd3);
    step(0, 1, 0, 8, 0, 0, 0);
    step(0, 1, 0, 8, 0, 0, 1);
    step(0, 1, 0, 8, 0, 12, 0);
    step(0, 0, 0, 8, 0, 5, 0);
    step(0, 1, 0, 8, 0, 5, 0);
    step(0, 1, 0, 8, 0, 12, 0);
    step(0, 1, 0, 8, 0, 5, 0);
    step(0, 1, 0, 8, 0, 5, 1);
    chk("clear_vs_fail", 32'(if8.first_fail_ch), 32'd1);
    step(0, 1, 0, 8, 12, 0, 0);
    step(1, 1, 0, 8, 3, 0, 0);
    step(0, 1, 0, 8, 3, 0, 0);
    thr = 8; md = 0;
    for (int n = 0; n < 3000; n++) begin
      int v[2];
      if ($urandom_range(0, 9) == 0) thr = ($urandom_range(0, 4) == 0) ? 8 : $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) md = $urandom_range(0, 1);
      for (int c = 0; c < 2; c++) begin
        int s = $urandom_range(0, 9);
        v[c] = s < 4 ? 0 : s < 7 ? (thr < 15 ? $urandom_range(thr + 1, 15) : 15) : $urandom_range(0, 15);
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 49) != 0, md[0], thr, v[0], v[1],
           $urandom_range(0, 24) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/threshold_reset_monitor.md
THRESHOLD_RESET_MONITOR -- requirements
Module: threshold_reset_monitor

Interface
REQ-001 Parameter NUM_CH, default 2: number of monitored channels, range 1..16.
REQ-002 Parameter WIDTH, default 4: bit width of each monitored value and of the threshold.
REQ-003 Parameter DEADLINE, default 2: response window in cycles, minimum 1.
REQ-004 Parameter CNT_W, default 8: width of the fail counter.
REQ-005 clk  input  1  single clock; all state is updated on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 enable  input  1  global check enable; low means monitoring is disabled.
REQ-008 mode  input  1  0 = WINDOW (reset due within DEADLINE cycles), 1 = EXACT (reset due exactly at DEADLINE cycles).
REQ-009 threshold  input  WIDTH  unsigned trigger threshold, shared by all channels.
REQ-010 value  input  NUM_CH*WIDTH  packed per-channel unsigned values; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 clear  input  1  clears the sticky flags, fail_count and the first-fail capture.
REQ-012 pass_pulse  output  NUM_CH  one-cycle pulse per channel when a check passes.
REQ-013 fail_pulse  output  NUM_CH  one-cycle pulse per channel when a check fails.
REQ-014 fail_sticky  output  NUM_CH  per-channel fail flag; holds until clear.
REQ-015 fail_count  output  CNT_W  total number of fails across all channels; saturating.
REQ-016 first_fail_valid  output  1  high when first_fail_ch holds a captured channel.
REQ-017 first_fail_ch  output  $clog2(NUM_CH) (min 1)  index of the first channel to fail since reset or the last clear.

Function
REQ-018 Each channel SHALL run an independent FSM with states IDLE and ARMED; ARMED carries an elapsed-cycle counter k.
REQ-019 IDLE->ARMED: at an edge where enable=1 and value_i > threshold (unsigned, strict); k is set to 0 at that edge.
REQ-020 While a channel is ARMED, k SHALL increment at each edge, and further triggers on that channel SHALL be ignored (checks do not overlap).
REQ-021 WINDOW mode: the check passes at the first edge with 1<=k<=DEADLINE and value_i==0; it fails at edge k==DEADLINE if value_i!=0. Either result returns the channel to IDLE.
REQ-022 EXACT mode: the check is decided only at edge k==DEADLINE: value_i==0 passes, anything else fails. Zeros seen earlier in the window are ignored.
REQ-023 mode and threshold SHALL be captured per channel at the trigger edge; changing them while a channel is ARMED SHALL have no effect on that check.
REQ-024 On a fail edge where value_i > threshold, the channel SHALL re-arm on the same edge with k=0.
REQ-025 pass_pulse and fail_pulse SHALL be registered and go high in the cycle after the deciding edge, for exactly one cycle; both SHALL never be high together on one channel.
REQ-026 fail_sticky[i] SHALL set together with fail_pulse[i].
REQ-027 fail_count SHALL add the popcount of the fails decided at each edge and saturate at 2^CNT_W-1.
REQ-028 On the first fail after reset or clear, first_fail_ch SHALL capture the lowest failing index and first_fail_valid SHALL go high; both hold until clear.
REQ-029 When clear and new fails occur on the same edge, the new fail SHALL win: sticky is set, count = new fails, and the capture is updated.
REQ-030 When enable=0 at an edge, every channel SHALL return to IDLE with no pulse; sticky flags, fail_count and the capture SHALL be kept.

Reset
REQ-031 When rst=1 at an edge, every channel SHALL go to IDLE with k=0, and all outputs SHALL be 0.
REQ-032 Reset SHALL override enable, clear and triggers; an in-flight check SHALL be discarded without a pulse.

Structure
REQ-033 Package threshold_reset_monitor_pkg SHALL hold the mode_e enum (WINDOW, EXACT) and the ch_state_e enum (IDLE, ARMED).
REQ-034 Sub-module threshold_reset_monitor_ch SHALL implement one channel FSM and be instantiated NUM_CH times in a generate loop; aggregation (sticky flags, fail_count, first-fail capture) stays in the top module.

Verification (NUM_CH=2, WIDTH=4, DEADLINE=2, threshold=8)
REQ-035 WINDOW: ch0 value 9 at edge t, 0 at edge t+1 -> pass_pulse[0] high for one cycle after edge t+1; no fail.
REQ-036 EXACT: ch0 value 9, 0, 3 at edges t, t+1, t+2 -> fail_pulse[0] after edge t+2; fail_count=1; first_fail_ch=0.
REQ-037 Both channels 12 at edge t, held at 12 -> both fail at edge t+2; fail_count=2; first_fail_ch=0; both re-arm at edge t+2.
REQ-038 ch1 armed, enable dropped at edge t+1 -> no pulse; ch1 IDLE; sticky flags and fail_count unchanged.
REQ-039 clear and a ch1 fail on the same edge -> fail_sticky=2'b10, fail_count=1, first_fail_ch=1.
REQ-040 With CNT_W=2, five fails -> fail_count saturates at 3; rst mid-window -> all outputs 0 and no pulse.
